// File: rtl/mac_pkg.sv
// Shared width helpers and the result-fitting function for the MAC pipeline.
// Wide values are carried in a fixed 128-bit signed container.
package mac_pkg;

    localparam int unsigned MAX_W = 128;

    typedef logic signed [MAX_W-1:0] wide_t;

    function automatic int unsigned acc_width(int unsigned in_w, int unsigned taps);
        return 2 * in_w + $clog2(taps);
    endfunction

    function automatic logic fits(wide_t v, int unsigned w);
        wide_t lim;
        if (w >= MAX_W) return 1'b1;
        lim = wide_t'(1) <<< (w - 1);
        return (v < lim) && (v >= -lim);
    endfunction

    // Clamp or wrap v into a w-bit signed range; the result stays sign-extended.
    function automatic wide_t fit(wide_t v, int unsigned w, logic sat);
        wide_t lim;
        if (fits(v, w)) return v;
        lim = wide_t'(1) <<< (w - 1);
        if (sat) return v[MAX_W-1] ? -lim : lim - wide_t'(1);
        return (v <<< (MAX_W - w)) >>> (MAX_W - w);
    endfunction

endpackage

// File: rtl/mac_nbit_pipe_stage1.sv
// Product stage: multiplier followed by the registered product, valid, last-tap and mode flags.
module mac_nbit_pipe_stage1
    import mac_pkg::*;
#(
    parameter int unsigned IN_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         accept,
    input  logic                         clr,
    input  logic signed [IN_WIDTH-1:0]   a,
    input  logic signed [IN_WIDTH-1:0]   b,
    input  logic                         sat_en,
    input  logic                         last,
    output logic signed [2*IN_WIDTH-1:0] p1,
    output logic                         v1,
    output logic                         last1,
    output logic                         sat1
);

    logic signed [2*IN_WIDTH-1:0] prod;

    mult_nbit #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (2 * IN_WIDTH)
    ) u_mult (
        .a (a),
        .b (b),
        .p (prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1    <= '0;
            v1    <= 1'b0;
            last1 <= 1'b0;
            sat1  <= 1'b0;
        end else if (clr) begin
            v1    <= 1'b0;
        end else if (en) begin
            v1 <= accept;
            if (accept) begin
                p1    <= prod;
                last1 <= last;
                sat1  <= sat_en;
            end
        end
    end

endmodule

// File: rtl/mult_nbit.sv
// Combinational signed multiplier; the product is sign-extended or truncated to OUT_WIDTH.
module mult_nbit #(
    parameter int unsigned IN_WIDTH  = 16,
    parameter int unsigned OUT_WIDTH = 32
) (
    input  logic signed [IN_WIDTH-1:0]  a,
    input  logic signed [IN_WIDTH-1:0]  b,
    output logic signed [OUT_WIDTH-1:0] p
);

    localparam int unsigned FULL_W = 2 * IN_WIDTH;

    logic signed [FULL_W-1:0] ae;
    logic signed [FULL_W-1:0] be;
    logic signed [FULL_W-1:0] full;

    assign ae   = {{IN_WIDTH{a[IN_WIDTH-1]}}, a};
    assign be   = {{IN_WIDTH{b[IN_WIDTH-1]}}, b};
    assign full = ae * be;

    if (OUT_WIDTH == FULL_W) begin : g_exact
        assign p = full;
    end else if (OUT_WIDTH > FULL_W) begin : g_extend
        assign p = {{(OUT_WIDTH - FULL_W){full[FULL_W-1]}}, full};
    end else begin : g_trunc
        assign p = full[OUT_WIDTH-1:0];
    end

endmodule

// File: rtl/mac_nbit_pipe.sv
// Pipelined signed multiply-accumulate: TAPS products per output word, with
// valid/ready on both sides and a saturate/wrap result mode.
module mac_nbit_pipe
    import mac_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 16,
    parameter int unsigned OUT_WIDTH = 38,
    parameter int unsigned TAPS      = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        sat_en,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [IN_WIDTH-1:0]  in_a,
    input  logic signed [IN_WIDTH-1:0]  in_b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic                        out_ovf
);

    localparam int unsigned ACC_W = acc_width(IN_WIDTH, TAPS);
    localparam int unsigned PW    = 2 * IN_WIDTH;
    localparam int unsigned CNT_W = $clog2(TAPS);

    logic                     en;
    logic                     accept;
    logic [CNT_W-1:0]         tap_cnt_q;
    logic                     last_tap;
    logic signed [PW-1:0]     p1;
    logic                     v1;
    logic                     last1;
    logic                     sat1;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  sum;
    wide_t                    sum_w;
    wide_t                    fitted;
    logic                     load;

    assign en       = !out_valid || out_ready;
    assign in_ready = en && !clr;
    assign accept   = in_valid && in_ready;
    assign last_tap = (tap_cnt_q == CNT_W'(TAPS - 1));

    mac_nbit_pipe_stage1 #(
        .IN_WIDTH (IN_WIDTH)
    ) u_stage1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .accept (accept),
        .clr    (clr),
        .a      (in_a),
        .b      (in_b),
        .sat_en (sat_en),
        .last   (last_tap),
        .p1     (p1),
        .v1     (v1),
        .last1  (last1),
        .sat1   (sat1)
    );

    // Accumulator is wide enough that this addition can never overflow.
    assign sum    = acc_q + {{(ACC_W - PW){p1[PW-1]}}, p1};
    assign sum_w  = {{(MAX_W - ACC_W){sum[ACC_W-1]}}, sum};
    assign fitted = fit(sum_w, OUT_WIDTH, sat1);
    assign load   = en && v1 && last1 && !clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_cnt_q <= '0;
        end else if (clr) begin
            tap_cnt_q <= '0;
        end else if (accept) begin
            tap_cnt_q <= last_tap ? '0 : tap_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en && v1) begin
            acc_q <= last1 ? '0 : sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= fitted[OUT_WIDTH-1:0];
            out_ovf   <= !fits(sum_w, OUT_WIDTH);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/mac_nbit_pipe.md
# mac_nbit_pipe

Pipelined, parametrised signed multiply-accumulate engine for the FIR datapath. It extends the combinational `mult_nbit` product with four additions: a registered product stage, a TAPS-deep accumulator, valid/ready handshakes on both sides, and a selectable saturate/wrap output mode. Each group of TAPS accepted (coefficient, sample) pairs produces one filtered output word.

## Interface
Parameters:
- IN_WIDTH, 16, signed width of each multiplicand.
- OUT_WIDTH, 38, signed width of the result; may be narrower than the internal accumulator.
- TAPS, 64, products summed per output; must be ≥ 2.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous flush of the partial sum, tap counter and product stage.
- sat_en  in  1  1 = saturate the result, 0 = wrap; sampled with the last tap of a group.
- in_valid  in  1  a/b pair offered.
- in_ready  out  1  pair accepted when in_valid & in_ready.
- in_a  in  IN_WIDTH  signed coefficient.
- in_b  in  IN_WIDTH  signed sample.
- out_valid  out  1  result held.
- out_ready  in  1  result consumed when out_valid & out_ready.
- out_data  out  OUT_WIDTH  signed result.
- out_ovf  out  1  the full-precision sum did not fit in OUT_WIDTH.

## Operation
- Accumulator width: ACC_W = 2*IN_WIDTH + clog2(TAPS). The accumulator never overflows internally, including when every product is (−2^(IN_WIDTH−1))².
- Pipeline enable: en = !out_valid | out_ready. in_ready = en & !clr. When en = 0, all stages freeze.
- Stage 1 (product register):
  - On accept, registers p1 = in_a*in_b (2*IN_WIDTH bits), v1 = 1 and last1 = (tap_cnt == TAPS−1).
  - Also captures sat1 = sat_en.
  - tap_cnt increments and wraps from TAPS−1 to 0.
  - When en = 1 and there is no accept, v1 = 0.
- Stage 2 (accumulate):
  - When en & v1 & !last1: acc <= acc + sext(p1).
  - When en & v1 & last1: sum = acc + sext(p1); out_data <= fit(sum); out_ovf <= (sum outside the OUT_WIDTH signed range); out_valid <= 1; acc <= 0.
- fit():
  - If OUT_WIDTH ≥ ACC_W: sign-extend.
  - Else, if sat1 = 1: clamp to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1].
  - Else (sat1 = 0): truncate to the low OUT_WIDTH bits.
  - out_ovf is reported in both modes.
- Output register:
  - out_valid clears on out_ready when no new result is loaded.
  - A simultaneous consume and load keeps out_valid = 1 with the new data.
- clr:
  - Zeroes acc, tap_cnt and v1 on the next edge.
  - Does not touch the output register.
  - If clr coincides with in_valid, the pair is not accepted, because in_ready = 0.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_ovf = 0, acc = 0, tap_cnt = 0, v1 = 0. in_ready = 1 after reset (it is combinational).
- Latency: the last tap accepted at edge N gives out_valid = 1 after edge N+1.
- Throughput: one tap per cycle. With out_ready held high, consecutive results appear every TAPS cycles.
- Backpressure:
  - When out_valid = 1 and out_ready = 0, in_ready = 0 in the same cycle.
  - No pair is dropped or duplicated.
  - out_data and out_ovf stay stable while out_valid = 1 and out_ready = 0.
- Reset mid-group: the partial sum is discarded immediately. The first accepted pair after rst_n deasserts is tap 0.

## Structure
- Package `mac_pkg`:
  - acc_width function (2*IN_WIDTH + clog2(TAPS)).
  - fit/saturate function, parametrised on widths.
- Sub-module: stage 1 instantiates `mult_nbit` with OUT_WIDTH = 2*IN_WIDTH, followed by the stage-1 register.
- Remaining content: tap counter, accumulator and output register.

## Test plan
- Basic group (IN_WIDTH=16, OUT_WIDTH=38, TAPS=4): four pairs a=3, b=−5, out_ready=1 -> out_data = −60, out_ovf = 0, out_valid high exactly one cycle after the last-tap edge.
- Extreme operands (OUT_WIDTH=32, TAPS=4): four pairs a=b=−32768.
  - With sat_en=1 -> out_data = 2147483647, out_ovf = 1.
  - With sat_en=0 -> out_data = 0 (2^32 wrapped), out_ovf = 1.
  - With OUT_WIDTH=38 -> 4294967296, out_ovf = 0.
- Backpressure: stream 8 pairs (a=1, b=1..8) continuously with out_ready=0 until cycle 10 -> in_ready drops while the first result (10) is held. After release, the second result 26 follows with no lost taps.
- Flush: after 2 taps (a=b=100), assert clr for one cycle, then send 4 taps a=1, b=2 -> out_data = 8.
- Reset mid-group: drop rst_n after 3 taps -> all outputs read 0 during reset. A fresh 4-tap group of a=2, b=7 -> 56.
- Back-to-back: two groups (all a=b=1, then all a=1, b=−1) with in_valid=1 and out_ready=1 -> outputs 4 and −4 exactly 4 cycles apart, with in_ready high throughout.
